// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default VGA timing constants, counter helpers and lock FSM states
package vga_timing_pkg;

    localparam int H_TOTAL_DEF  = 800;
    localparam int V_TOTAL_DEF  = 525;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    localparam int              CNT_W   = 13;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } sync_state_t;

    // Measurement counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - input register for an active-low sync with a one-cycle falling-edge pulse
module sync_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic sync_n,
    output logic fall
);

    logic sync_q;
    logic sync_d;

    // Idle level is high so leaving reset never produces a false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 1'b1;
            sync_d <= 1'b1;
        end else begin
            sync_q <= sync_n;
            sync_d <= sync_q;
        end
    end

    assign fall = sync_d & ~sync_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - VGA timing decoder with lock FSM; VGA_FRAME_CHECKSUM_EN adds a per-frame pixel checksum
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL     = H_TOTAL_DEF,
    parameter int V_TOTAL     = V_TOTAL_DEF,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        VGA_CLK,
    input  logic        RESET,
    input  logic        VGA_HS,
    input  logic        VGA_VS,
    input  logic        VGA_BLANK_N,
    input  logic [7:0]  VGA_R,
    input  logic [7:0]  VGA_G,
    input  logic [7:0]  VGA_B,
    output logic [7:0]  pix_R,
    output logic [7:0]  pix_G,
    output logic [7:0]  pix_B,
    output logic [12:0] col,
    output logic [12:0] row,
    output logic        active,
    output logic [12:0] h_total,
    output logic [12:0] v_total,
    output logic        locked,
    output logic        sync_err,
    output logic [15:0] frame_sum
);

    localparam logic [CNT_W-1:0] H_EXP   = CNT_W'(H_TOTAL);
    localparam logic [CNT_W-1:0] V_EXP   = CNT_W'(V_TOTAL);
    localparam logic [CNT_W-1:0] H_LIMIT = CNT_W'(2 * H_TOTAL);
    localparam logic [7:0]       LOCK_N  = 8'(LOCK_FRAMES);

    logic       blank_q;
    logic [7:0] r_q, g_q, b_q;
    logic       hs_fall, vs_fall;

    sync_edge_det u_hs_det (.clk(VGA_CLK), .reset(RESET), .sync_n(VGA_HS), .fall(hs_fall));
    sync_edge_det u_vs_det (.clk(VGA_CLK), .reset(RESET), .sync_n(VGA_VS), .fall(vs_fall));

    always_ff @(posedge VGA_CLK) begin
        if (RESET) begin
            blank_q <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            blank_q <= VGA_BLANK_N;
            r_q     <= VGA_R;
            g_q     <= VGA_G;
            b_q     <= VGA_B;
        end
    end

    logic [CNT_W-1:0] clk_cnt;
    logic [CNT_W-1:0] line_cnt;
    logic [CNT_W-1:0] lines_now;
    logic             frame_ok;
    logic             line_good;
    logic             frame_good;
    logic             timeout;

    // An HS fall coinciding with a VS fall closes its line before the frame is judged.
    assign line_good  = (clk_cnt == H_EXP);
    assign lines_now  = hs_fall ? sat_inc(line_cnt) : line_cnt;
    assign frame_good = frame_ok && (!hs_fall || line_good) && (lines_now == V_EXP);
    assign timeout    = (clk_cnt > H_LIMIT);

    always_ff @(posedge VGA_CLK) begin
        if (RESET) begin
            clk_cnt  <= '0;
            line_cnt <= '0;
            frame_ok <= 1'b0;
            h_total  <= '0;
            v_total  <= '0;
        end else begin
            if (hs_fall) begin
                clk_cnt <= CNT_W'(1);
                h_total <= clk_cnt;
            end else begin
                clk_cnt <= sat_inc(clk_cnt);
            end
            if (vs_fall) begin
                v_total  <= lines_now;
                line_cnt <= '0;
                frame_ok <= 1'b1;
            end else begin
                line_cnt <= lines_now;
                if (hs_fall && !line_good)
                    frame_ok <= 1'b0;
            end
        end
    end

    sync_state_t state_q, state_d;
    logic [7:0]  good_q, good_d;
    logic        err_d;

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        err_d   = 1'b0;
        if (timeout) begin
            state_d = SEARCH;
            good_d  = '0;
            err_d   = (state_q == LOCKED);
        end else begin
            case (state_q)
                SEARCH: begin
                    if (vs_fall) begin
                        state_d = CHECK;
                        good_d  = '0;
                    end
                end
                CHECK: begin
                    if (vs_fall) begin
                        if (frame_good) begin
                            good_d = good_q + 8'd1;
                            if (good_d >= LOCK_N)
                                state_d = LOCKED;
                        end else begin
                            good_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    if ((hs_fall && !line_good) || (vs_fall && (lines_now != V_EXP))) begin
                        state_d = CHECK;
                        good_d  = '0;
                        err_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = SEARCH;
                    good_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge VGA_CLK) begin
        if (RESET) begin
            state_q  <= SEARCH;
            good_q   <= '0;
            sync_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            good_q   <= good_d;
            sync_err <= err_d;
        end
    end

    assign locked = (state_q == LOCKED);

    // line_act remembers whether the current line has shown a visible pixel yet.
    logic line_act;

    always_ff @(posedge VGA_CLK) begin
        if (RESET) begin
            pix_R    <= '0;
            pix_G    <= '0;
            pix_B    <= '0;
            active   <= 1'b0;
            col      <= '0;
            row      <= '0;
            line_act <= 1'b0;
        end else begin
            active <= blank_q;
            pix_R  <= blank_q ? r_q : 8'd0;
            pix_G  <= blank_q ? g_q : 8'd0;
            pix_B  <= blank_q ? b_q : 8'd0;
            if (hs_fall)
                line_act <= blank_q;
            else if (blank_q)
                line_act <= 1'b1;
            if (blank_q)
                col <= (hs_fall || !line_act) ? '0 : sat_inc(col);
            if (vs_fall)
                row <= '0;
            else if (hs_fall && line_act)
                row <= sat_inc(row);
        end
    end

`ifdef VGA_FRAME_CHECKSUM_EN
    logic [15:0] sum_acc;
    logic [15:0] pix_x;

    assign pix_x = {8'd0, r_q ^ g_q ^ b_q};

    always_ff @(posedge VGA_CLK) begin
        if (RESET) begin
            sum_acc   <= '0;
            frame_sum <= '0;
        end else if (vs_fall) begin
            frame_sum <= sum_acc;
            sum_acc   <= blank_q ? pix_x : 16'd0;
        end else if (blank_q) begin
            sum_acc <= sum_acc + pix_x;
        end
    end
`else
    assign frame_sum = '0;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - directed bench for vga_sync_decoder on a scaled 40x30 raster
`timescale 1ns/1ps
module tb_vga_sync_decoder;
    import vga_timing_pkg::*;

    localparam int H     = 40;
    localparam int V     = 30;
    localparam int LOCKF = 2;
    localparam int HS_A  = 2;
    localparam int HS_B  = 5;
    localparam int VS_A  = 3;
    localparam int VS_B  = 4;
    localparam int X0    = 10;
    localparam int Y0    = 6;

    logic        VGA_CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        VGA_HS = 1'b1;
    logic        VGA_VS = 1'b1;
    logic        VGA_BLANK_N = 1'b0;
    logic [7:0]  VGA_R = '0, VGA_G = '0, VGA_B = '0;
    logic [7:0]  pix_R, pix_G, pix_B;
    logic [12:0] col, row, h_total, v_total;
    logic        active, locked, sync_err;
    logic [15:0] frame_sum;

    int checks = 0;
    int failures = 0;
    int err_cnt = 0;
    bit chk_en = 1'b0;
    bit const_colour = 1'b0;
    bit rst_chk = 1'b0;
    int hx1 = -1, hy1 = -1, hx2 = -1, hy2 = -1;
    bit he1 = 1'b0, he2 = 1'b0;

    vga_sync_decoder #(.H_TOTAL(H), .V_TOTAL(V), .LOCK_FRAMES(LOCKF)) dut (
        .VGA_CLK(VGA_CLK), .RESET(RESET), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .pix_R(pix_R), .pix_G(pix_G), .pix_B(pix_B), .col(col), .row(row),
        .active(active), .h_total(h_total), .v_total(v_total), .locked(locked),
        .sync_err(sync_err), .frame_sum(frame_sum)
    );

    always #20 VGA_CLK = ~VGA_CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_pix_R"}, pix_R, 0);
        check_eq({tag, "_pix_G"}, pix_G, 0);
        check_eq({tag, "_pix_B"}, pix_B, 0);
        check_eq({tag, "_col"}, col, 0);
        check_eq({tag, "_row"}, row, 0);
        check_eq({tag, "_active"}, active, 0);
        check_eq({tag, "_h_total"}, h_total, 0);
        check_eq({tag, "_v_total"}, v_total, 0);
        check_eq({tag, "_locked"}, locked, 0);
        check_eq({tag, "_sync_err"}, sync_err, 0);
        check_eq({tag, "_frame_sum"}, frame_sum, 0);
    endtask

    task automatic check_pixel(input int x, input int y);
        if (x == 10 && y == 6) begin
            check_eq("first_col", col, 0);
            check_eq("first_row", row, 0);
            check_eq("first_active", active, 1);
            check_eq("first_pix_R", pix_R, 10);
            check_eq("first_pix_G", pix_G, 6);
            check_eq("first_pix_B", pix_B, 16);
        end else if (x == 39 && y == 29) begin
            check_eq("last_col", col, 29);
            check_eq("last_row", row, 23);
            check_eq("last_pix_B", pix_B, 68);
        end else if (x == 25 && y == 12) begin
            check_eq("mid_col", col, 15);
            check_eq("mid_row", row, 6);
            check_eq("mid_pix_R", pix_R, 25);
            check_eq("mid_pix_G", pix_G, 12);
        end else if (x == 5 && y == 10) begin
            check_eq("blank_active", active, 0);
            check_eq("blank_pix_G", pix_G, 0);
            check_eq("blank_col_hold", col, 29);
            check_eq("blank_row", row, 4);
        end
    endtask

    // Outputs seen at a negedge describe the pixel driven two ticks earlier.
    task automatic tick(input int x, input int y, input logic hs, input logic vs,
                        input logic blank, input logic rst);
        @(negedge VGA_CLK);
        if (sync_err) err_cnt++;
        if (rst_chk) check_zero("reset");
        if (he2) check_pixel(hx2, hy2);
        hx2 = hx1; hy2 = hy1; he2 = he1;
        hx1 = x;   hy1 = y;   he1 = chk_en;
        RESET       = rst;
        VGA_HS      = hs;
        VGA_VS      = vs;
        VGA_BLANK_N = blank;
        VGA_R       = const_colour ? 8'd1 : 8'(x);
        VGA_G       = const_colour ? 8'd2 : 8'(y);
        VGA_B       = const_colour ? 8'd4 : 8'(x + y);
        rst_chk     = rst;
    endtask

    task automatic run_frame(input bit en, input int bad_y, input int rst_x, input int rst_y);
        chk_en = en;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < ((y == bad_y) ? H - 1 : H); x++)
                tick(x, y, !(x >= HS_A && x <= HS_B), !(y >= VS_A && y <= VS_B),
                     (x >= X0 && y >= Y0), (x == rst_x && y == rst_y));
        end
        chk_en = 1'b0;
    endtask

    initial begin
        tick(-1, -1, 1'b1, 1'b1, 1'b0, 1'b1);
        tick(-1, -1, 1'b1, 1'b1, 1'b0, 1'b1);

        run_frame(1'b1, -1, -1, -1);
        run_frame(1'b0, -1, -1, -1);
        check_eq("f1_locked", locked, 0);
        check_eq("f1_h_total", h_total, 40);
        check_eq("f1_v_total", v_total, 30);
        run_frame(1'b0, -1, -1, -1);
        check_eq("f2_locked", locked, 1);
        run_frame(1'b0, -1, -1, -1);
        check_eq("f3_locked", locked, 1);
        check_eq("f3_no_err", err_cnt, 0);

        err_cnt = 0;
        run_frame(1'b0, 10, -1, -1);
        check_eq("short_err", err_cnt, 1);
        check_eq("short_locked", locked, 0);
        run_frame(1'b0, -1, -1, -1);
        check_eq("short_f5_locked", locked, 0);
        run_frame(1'b0, -1, -1, -1);
        check_eq("short_f6_locked", locked, 0);
        run_frame(1'b0, -1, -1, -1);
        check_eq("short_f7_locked", locked, 1);
        check_eq("short_err_once", err_cnt, 1);

        err_cnt = 0;
        for (int i = 0; i < 2 * H + 1; i++) tick(-1, -1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("timeout_err", err_cnt, 1);
        check_eq("timeout_locked", locked, 0);
        check_eq("timeout_state", dut.state_q, SEARCH);
        run_frame(1'b0, -1, -1, -1);
        check_eq("rec_f8_locked", locked, 0);
        run_frame(1'b0, -1, -1, -1);
        check_eq("rec_f9_locked", locked, 0);
        run_frame(1'b0, -1, -1, -1);
        check_eq("rec_f10_locked", locked, 1);

        run_frame(1'b0, -1, 20, 15);
        check_eq("rst_f11_locked", locked, 0);
        run_frame(1'b0, -1, -1, -1);
        check_eq("rst_f12_locked", locked, 0);
        run_frame(1'b0, -1, -1, -1);
        check_eq("rst_f13_locked", locked, 0);
        run_frame(1'b0, -1, -1, -1);
        check_eq("rst_f14_locked", locked, 1);

        const_colour = 1'b1;
        run_frame(1'b0, -1, -1, -1);
        run_frame(1'b0, -1, -1, -1);
`ifdef VGA_FRAME_CHECKSUM_EN
        check_eq("frame_sum", frame_sum, 5040);
`else
        check_eq("frame_sum", frame_sum, 0);
`endif
        check_eq("final_h_total", h_total, 40);
        check_eq("final_v_total", v_total, 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
